// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one i2c_master command port among N_REQ requesters.
// Optional define I2C_ARB_PRIO_EN: requester 0 gets fixed top priority, the rest round-robin.
module i2c_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic               m_start,
  output logic               m_stop,
  output logic               m_rw,
  output logic [6:0]         m_addr,
  output logic [7:0]         m_wdata,
  input  logic               m_idle,
  output logic               busy
);

  // state     | meaning
  // IDLE      | arbitrate, latch winner command, raise gnt
  // GRANT     | launch: m_start pulse and m_stop registered for next cycle
  // WAIT_BUSY | wait for master to leave idle (timed)
  // WAIT_IDLE | wait for master to return to idle (timed)
  // DONE      | done pulse visible, advance rr_ptr, release gnt
  // ERR       | err pulse visible, advance rr_ptr, release gnt
  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_WAIT_BUSY, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  localparam int PW  = $clog2(N_REQ);
  localparam int PW1 = PW + 1;
  localparam int TW  = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] P_LAST = PW'(N_REQ - 1);
  localparam logic [PW:0]   N_WRAP = PW1'(N_REQ);

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    win;
  logic [PW-1:0]    win_sel;
  logic [PW-1:0]    ptr_next;
  logic [TW-1:0]    timer;
  logic             any_req;
  logic [N_REQ-1:0] rr_req;
  logic [N_REQ-1:0] sel_oh;
  logic [PW:0]      idx;
  logic             sel_rw;
  logic [6:0]       sel_addr;
  logic [7:0]       sel_wdata;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    rr_req = req;
`ifdef I2C_ARB_PRIO_EN
    rr_req[0] = 1'b0;
`endif
    any_req = 1'b0;
    win_sel = '0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + PW1'(k);
      if (idx >= N_WRAP) idx = idx - N_WRAP;
      if (rr_req[idx[PW-1:0]]) begin
        any_req = 1'b1;
        win_sel = idx[PW-1:0];
      end
    end
`ifdef I2C_ARB_PRIO_EN
    if (req[0]) begin
      any_req = 1'b1;
      win_sel = '0;
    end
`endif
  end

  always_comb begin
    sel_oh    = '0;
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_sel == PW'(i)) begin
        sel_oh[i] = 1'b1;
        sel_rw    = req_rw[i];
        sel_addr  = req_addr[7*i +: 7];
        sel_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  assign ptr_next = (win == P_LAST) ? '0 : win + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      win     <= '0;
      timer   <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      m_start <= 1'b0;
      m_stop  <= 1'b0;
      m_rw    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      busy    <= 1'b0;
    end else begin
      m_start <= 1'b0;
      done    <= '0;
      err     <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state   <= S_GRANT;
            win     <= win_sel;
            gnt     <= sel_oh;
            m_rw    <= sel_rw;
            m_addr  <= sel_addr;
            m_wdata <= sel_wdata;
            busy    <= 1'b1;
          end
        end
        S_GRANT: begin
          m_start <= 1'b1;
          m_stop  <= 1'b1;
          timer   <= '0;
          state   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!m_idle) begin
            state <= S_WAIT_IDLE;
            timer <= '0;
          end else if (timer == T_LAST) begin
            state <= S_ERR;
            err   <= gnt;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (m_idle) begin
            state <= S_DONE;
            done  <= gnt;
          end else if (timer == T_LAST) begin
            state <= S_ERR;
            err   <= gnt;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          state  <= S_IDLE;
          gnt    <= '0;
          busy   <= 1'b0;
          m_stop <= 1'b0;
`ifdef I2C_ARB_PRIO_EN
          // A priority win by requester 0 leaves the rotation untouched.
          if (win != '0) rr_ptr <= ptr_next;
`else
          rr_ptr <= ptr_next;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter: behavioural master, arbitration reference model, random traffic.
module tb_i2c_req_arbiter;
  localparam int N  = 4;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_rw = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [N-1:0]   gnt, done, err;
  logic           m_start, m_stop, m_rw;
  logic [6:0]     m_addr;
  logic [7:0]     m_wdata;
  logic           m_idle = 1'b1;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int         mdl_ptr = 0;
  logic       exp_rw   [N];
  logic [6:0] exp_addr [N];
  logic [7:0] exp_wd   [N];

  // master model: 0 normal, 1 ignores start, 2 goes busy and hangs
  int mst_mode = 0;
  int mst_len  = 4;
  int mst_cnt  = 0;

  // observation results of one transaction
  logic [N-1:0] ob_gnt, ob_done, ob_err;
  logic [15:0]  ob_cmd;
  int ob_gwait, ob_start_ofs, ob_starts, ob_n_done, ob_n_err, ob_len;
  bit ob_cmd_stable, ob_gnt_stable, ob_stop_ok, ob_busy_ok, ob_gap_ok;

  i2c_req_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .m_start(m_start),
    .m_stop(m_stop), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_idle(m_idle), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      m_idle  = 1'b1;
      mst_cnt = 0;
    end else if (m_idle) begin
      if (m_start && mst_mode != 1) begin
        m_idle  = 1'b0;
        mst_cnt = mst_len;
      end
    end else if (mst_mode != 2) begin
      mst_cnt--;
      if (mst_cnt <= 0) m_idle = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int mdl_pick(input logic [N-1:0] mask);
    int m, j;
    m = int'(mask);
`ifdef I2C_ARB_PRIO_EN
    if ((m & 1) == 1) return 0;
    m = m & ~1;
`endif
    for (int k = 0; k < N; k++) begin
      j = (mdl_ptr + k) % N;
      if (((m >> j) & 1) == 1) return j;
    end
    return -1;
  endfunction

  task automatic mdl_retire(input int w);
`ifdef I2C_ARB_PRIO_EN
    if (w != 0) mdl_ptr = (w + 1) % N;
`else
    mdl_ptr = (w + 1) % N;
`endif
  endtask

  task automatic set_cmd(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
    req_rw[i]          = rw;
    req_addr[7*i +: 7] = a;
    req_wdata[8*i +: 8] = d;
    exp_rw[i]   = rw;
    exp_addr[i] = a;
    exp_wd[i]   = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; mst_mode = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0; mdl_ptr = 0;
    @(negedge clk);
  endtask

  // Collects what one transaction looks like; callers do the comparisons.
  task automatic observe_txn(input bit withdraw);
    int cyc;
    bit fin;
    ob_gnt = '0; ob_done = '0; ob_err = '0; ob_cmd = '0;
    ob_gwait = 0; ob_start_ofs = -1; ob_starts = 0; ob_n_done = 0; ob_n_err = 0; ob_len = -1;
    ob_cmd_stable = 1; ob_gnt_stable = 1; ob_stop_ok = 1; ob_busy_ok = 1; ob_gap_ok = 0;
    while (ob_gnt == '0 && ob_gwait < 200) begin
      @(negedge clk);
      ob_gwait++;
      if (gnt != '0) ob_gnt = gnt;
    end
    if (ob_gnt == '0) return;
    ob_cmd = {m_rw, m_addr, m_wdata};
    if (withdraw) req = req & ~ob_gnt;
    cyc = 0;
    fin = 0;
    while (!fin && cyc < 400) begin
      if (m_start) begin
        ob_starts++;
        if (ob_start_ofs < 0) ob_start_ofs = cyc;
      end
      if (ob_start_ofs >= 0 && !m_stop) ob_stop_ok = 0;
      if ({m_rw, m_addr, m_wdata} !== ob_cmd) ob_cmd_stable = 0;
      if (gnt !== ob_gnt) ob_gnt_stable = 0;
      if (!busy) ob_busy_ok = 0;
      if (done != '0) begin ob_done |= done; ob_n_done++; end
      if (err != '0) begin ob_err |= err; ob_n_err++; end
      if (done != '0 || err != '0) begin
        fin = 1;
        ob_len = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    @(negedge clk);
    ob_gap_ok = (gnt == '0) && !busy && !m_start;
    if (done != '0) ob_n_done++;
    if (err != '0) ob_n_err++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if ({gnt, done, err, m_start, m_stop, m_rw, m_addr, m_wdata, busy} !== '0) begin n_bad++; $display("FAIL reset outputs: got %h expected 0", {gnt, done, err, m_start, m_stop, m_rw, m_addr, m_wdata, busy}); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({gnt, done, err, m_start, m_stop, busy} !== '0) begin n_bad++; $display("FAIL reset idle quiet: got %h expected 0", {gnt, done, err, m_start, m_stop, busy}); end
  endtask

  task automatic test_single_write();
    int exp_len;
    do_reset();
    mst_mode = 0; mst_len = 20;
    set_cmd(1, 1'b0, 7'h50, 8'hA5);
    req = 4'b0010;
    observe_txn(1'b0);
    req = '0;
    mdl_retire(1);
    // grant cycle, start cycle, then the master stays busy for mst_len cycles
    exp_len = mst_len + 2;
    n_cmp++; if (ob_gnt !== 4'b0010) begin n_bad++; $display("FAIL single gnt: got %b expected 0010", ob_gnt); end
    n_cmp++; if (ob_gwait != 1) begin n_bad++; $display("FAIL single gnt latency: got %0d expected 1", ob_gwait); end
    n_cmp++; if (ob_start_ofs != 1) begin n_bad++; $display("FAIL single start offset: got %0d expected 1", ob_start_ofs); end
    n_cmp++; if (ob_starts != 1) begin n_bad++; $display("FAIL single start count: got %0d expected 1", ob_starts); end
    n_cmp++; if (ob_cmd !== {1'b0, 7'h50, 8'hA5}) begin n_bad++; $display("FAIL single cmd: got %h expected %h", ob_cmd, {1'b0, 7'h50, 8'hA5}); end
    n_cmp++; if (!ob_stop_ok || !ob_cmd_stable || !ob_gnt_stable || !ob_busy_ok) begin n_bad++; $display("FAIL single hold: got stop%0d cmd%0d gnt%0d busy%0d expected all 1", ob_stop_ok, ob_cmd_stable, ob_gnt_stable, ob_busy_ok); end
    n_cmp++; if (ob_done !== 4'b0010 || ob_n_done != 1 || ob_n_err != 0) begin n_bad++; $display("FAIL single done: got %b x%0d err x%0d expected 0010 x1 err x0", ob_done, ob_n_done, ob_n_err); end
    n_cmp++; if (ob_len != exp_len) begin n_bad++; $display("FAIL single length: got %0d expected %0d", ob_len, exp_len); end
    n_cmp++; if (!ob_gap_ok) begin n_bad++; $display("FAIL single idle gap: got 0 expected 1"); end
  endtask

  task automatic test_fairness();
    int w;
    logic [N-1:0] seen, exp_g;
    do_reset();
    mst_mode = 0; mst_len = 3;
    for (int i = 0; i < N; i++) set_cmd(i, 1'(i % 2), 7'(32 + i), 8'(17 * i));
    req = '1;
    seen = '0;
    for (int t = 0; t < N + 1; t++) begin
      w = mdl_pick(req);
      exp_g = N'(1) << w;
      observe_txn(1'b0);
      n_cmp++; if (ob_gnt !== exp_g) begin n_bad++; $display("FAIL fair gnt %0d: got %b expected %b", t, ob_gnt, exp_g); end
      n_cmp++; if (ob_cmd !== {exp_rw[w], exp_addr[w], exp_wd[w]}) begin n_bad++; $display("FAIL fair cmd %0d: got %h expected %h", t, ob_cmd, {exp_rw[w], exp_addr[w], exp_wd[w]}); end
      n_cmp++; if (ob_done !== exp_g || ob_n_done != 1) begin n_bad++; $display("FAIL fair done %0d: got %b x%0d expected %b x1", t, ob_done, ob_n_done, exp_g); end
      if (t < N) seen |= ob_gnt;
      mdl_retire(w);
    end
`ifndef I2C_ARB_PRIO_EN
    n_cmp++; if (seen !== '1) begin n_bad++; $display("FAIL fair coverage: got %b expected 1111", seen); end
`endif
    req = '0;
  endtask

  task automatic test_timeouts();
    int w;
    logic [N-1:0] exp_g;
    do_reset();
    mst_mode = 1; mst_len = 4;
    req = 4'b0100;
    observe_txn(1'b0);
    req = '0;
    mdl_retire(2);
    n_cmp++; if (ob_gnt !== 4'b0100) begin n_bad++; $display("FAIL tmo_busy gnt: got %b expected 0100", ob_gnt); end
    n_cmp++; if (ob_err !== 4'b0100 || ob_n_err != 1 || ob_n_done != 0) begin n_bad++; $display("FAIL tmo_busy err: got %b x%0d done x%0d expected 0100 x1 done x0", ob_err, ob_n_err, ob_n_done); end
    // grant cycle plus TIMEOUT waiting cycles
    n_cmp++; if (ob_len != TO + 1) begin n_bad++; $display("FAIL tmo_busy length: got %0d expected %0d", ob_len, TO + 1); end
    n_cmp++; if (!ob_gap_ok) begin n_bad++; $display("FAIL tmo_busy back to idle: got 0 expected 1"); end

    mst_mode = 2;
    req = 4'b1001;
    w = mdl_pick(req);
    exp_g = N'(1) << w;
    observe_txn(1'b0);
    req = '0;
    mdl_retire(w);
    n_cmp++; if (ob_gnt !== exp_g) begin n_bad++; $display("FAIL tmo_idle gnt: got %b expected %b", ob_gnt, exp_g); end
    n_cmp++; if (ob_err !== exp_g || ob_n_err != 1 || ob_n_done != 0) begin n_bad++; $display("FAIL tmo_idle err: got %b x%0d done x%0d expected %b x1 done x0", ob_err, ob_n_err, ob_n_done, exp_g); end
    // grant cycle, one cycle for the master to go busy, then TIMEOUT cycles
    n_cmp++; if (ob_len != TO + 2) begin n_bad++; $display("FAIL tmo_idle length: got %0d expected %0d", ob_len, TO + 2); end
    n_cmp++; if (!ob_stop_ok) begin n_bad++; $display("FAIL tmo_idle stop held: got 0 expected 1"); end

    mst_mode = 0;
    repeat (3) @(negedge clk);
    req = 4'b1001;
    w = mdl_pick(req);
    exp_g = N'(1) << w;
    observe_txn(1'b0);
    req = '0;
    mdl_retire(w);
    n_cmp++; if (ob_gnt !== exp_g) begin n_bad++; $display("FAIL tmo ptr advance: got %b expected %b", ob_gnt, exp_g); end
  endtask

  task automatic test_reset_mid();
    int w, k;
    logic [N-1:0] exp_g;
    do_reset();
    mst_mode = 0; mst_len = 5;
    for (int i = 0; i < N; i++) set_cmd(i, 1'b1, 7'(16 + i), 8'(192 + i));
    req = 4'b0010;
    observe_txn(1'b0);
    req = '0;
    mdl_retire(1);
    n_cmp++; if (ob_done !== 4'b0010) begin n_bad++; $display("FAIL rstmid pre done: got %b expected 0010", ob_done); end
    mst_mode = 2;
    req = 4'b0100;
    k = 0;
    while (gnt == '0 && k < 20) begin @(negedge clk); k++; end
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL rstmid grant: got %b expected 0100", gnt); end
    repeat (10) @(negedge clk);
    reset = 1'b1;
    req = '0;
    #1;
    n_cmp++; if ({gnt, done, err, m_start, m_stop, m_rw, m_addr, m_wdata, busy} !== '0) begin n_bad++; $display("FAIL rstmid async clear: got %h expected 0", {gnt, done, err, m_start, m_stop, m_rw, m_addr, m_wdata, busy}); end
    mst_mode = 0;
    k = 0;
    repeat (2) begin @(negedge clk); if (done != '0 || err != '0) k++; end
    reset = 1'b0;
    mdl_ptr = 0;
    repeat (3) begin @(negedge clk); if (done != '0 || err != '0 || gnt != '0) k++; end
    n_cmp++; if (k != 0) begin n_bad++; $display("FAIL rstmid stray pulses: got %0d expected 0", k); end
    req = 4'b1010;
    w = mdl_pick(req);
    exp_g = N'(1) << w;
    observe_txn(1'b0);
    mdl_retire(w);
    n_cmp++; if (ob_gnt !== exp_g) begin n_bad++; $display("FAIL rstmid ptr cleared: got %b expected %b", ob_gnt, exp_g); end
    req = 4'b1000;
    observe_txn(1'b0);
    req = '0;
    mdl_retire(3);
    n_cmp++; if (ob_gnt !== 4'b1000 || ob_done !== 4'b1000) begin n_bad++; $display("FAIL rstmid fresh req3: got gnt %b done %b expected 1000 1000", ob_gnt, ob_done); end
  endtask

  task automatic test_random();
    int w, exp_len;
    bit wd;
    logic [N-1:0] mask, exp_g;
    do_reset();
    mst_mode = 0;
    mask = 4'b0101;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) set_cmd(i, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));
      mst_len = $urandom_range(1, 12);
      wd = ($urandom_range(0, 3) == 0);
      w = mdl_pick(mask);
      exp_g = N'(1) << w;
      exp_len = mst_len + 2;
      req = mask;
      observe_txn(wd);
      n_cmp++; if (ob_gnt !== exp_g) begin n_bad++; $display("FAIL rand gnt %0d: got %b expected %b (req %b)", t, ob_gnt, exp_g, mask); end
      n_cmp++; if (ob_cmd !== {exp_rw[w], exp_addr[w], exp_wd[w]}) begin n_bad++; $display("FAIL rand cmd %0d: got %h expected %h", t, ob_cmd, {exp_rw[w], exp_addr[w], exp_wd[w]}); end
      n_cmp++; if (ob_done !== exp_g || ob_n_done != 1 || ob_n_err != 0) begin n_bad++; $display("FAIL rand done %0d: got %b x%0d err x%0d expected %b x1", t, ob_done, ob_n_done, ob_n_err, exp_g); end
      n_cmp++; if (ob_len != exp_len || ob_gwait != 1 || ob_starts != 1) begin n_bad++; $display("FAIL rand timing %0d: got len %0d wait %0d starts %0d expected %0d 1 1", t, ob_len, ob_gwait, ob_starts, exp_len); end
      n_cmp++; if (!ob_cmd_stable || !ob_gnt_stable || !ob_stop_ok || !ob_gap_ok) begin n_bad++; $display("FAIL rand hold %0d: got cmd%0d gnt%0d stop%0d gap%0d expected all 1", t, ob_cmd_stable, ob_gnt_stable, ob_stop_ok, ob_gap_ok); end
      mdl_retire(w);
      mask = (mask & ~exp_g) | N'($urandom_range(0, 15));
      if (mask == '0) mask = N'(1) << $urandom_range(0, N - 1);
    end
    req = '0;
  endtask

`ifdef I2C_ARB_PRIO_EN
  task automatic test_prio();
    do_reset();
    mst_mode = 0; mst_len = 2;
    req = 4'b1001;
    for (int t = 0; t < 3; t++) begin
      observe_txn(1'b0);
      n_cmp++; if (ob_gnt !== 4'b0001) begin n_bad++; $display("FAIL prio req0 win %0d: got %b expected 0001", t, ob_gnt); end
    end
    req = 4'b1000;
    observe_txn(1'b0);
    req = '0;
    n_cmp++; if (ob_gnt !== 4'b1000) begin n_bad++; $display("FAIL prio req3 after drop: got %b expected 1000", ob_gnt); end
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) begin
      exp_rw[i] = 1'b0; exp_addr[i] = '0; exp_wd[i] = '0;
    end
    test_reset();
    test_single_write();
    test_fairness();
    test_timeouts();
    test_reset_mid();
    test_random();
`ifdef I2C_ARB_PRIO_EN
    test_prio();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
